ssp_tx_ctrl: RTL and testbench

//   Transmit sequencer for the SSP master. Pops bytes from the TX FIFO (show-ahead),

---
 rtl/ssp_pkg.sv | 14 +
 rtl/ssp_clkgen.sv | 22 ++
 rtl/ssp_tx_ctrl.sv | 117 +++++++++++
 tb/tb_ssp_tx_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared sizing and state encoding for the SSP transmit path.
package ssp_pkg;

  localparam int unsigned SSP_DATA_W = 8;
  localparam int unsigned SSP_CNT_W  = $clog2(SSP_DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    SHIFT,
    LAST
  } tx_state_e;

endpackage

// File: rtl/ssp_clkgen.sv
// PCLK/2 serial clock divider; strobes flag whether the current edge is a rise or a fall.
module ssp_clkgen (
  input  logic clk,
  input  logic rst_n,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
    end else begin
      sclk <= ~sclk;
    end
  end

  // The edge about to happen flips sclk, so its current level names the edge.
  assign rise_c = ~sclk;
  assign fall_c = sclk;

endmodule

// File: rtl/ssp_tx_ctrl.sv
// Transmit sequencer for the SSP master: pops the TX FIFO and serialises each
// byte MSB-first behind a one-period SSPFSSOUT frame pulse.
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int unsigned DATA_W = SSP_DATA_W
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD,
  output logic              SSPOE_B,
  output logic              tx_busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              txd_d, fss_d, oe_b_d, rd_d, busy_d, load_c;
  logic              rise_c, fall_c;

  ssp_clkgen u_clkgen (
    .clk    (PCLK),
    .rst_n  (CLEAR_B),
    .sclk   (SSPCLKOUT),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Next-state and next-output logic; frame decisions are taken only on rise edges.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    txd_d   = SSPTXD;
    fss_d   = SSPFSSOUT;
    oe_b_d  = SSPOE_B;
    rd_d    = 1'b0;
    load_c  = 1'b0;

    unique case (state_q)
      IDLE: load_c = rise_c & ~fifo_empty;
      FRAME: begin
        if (fall_c) oe_b_d = 1'b0;
        if (rise_c) begin
          fss_d   = 1'b0;
          txd_d   = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_c) begin
          txd_d   = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (cnt_q == CNT_LAST) begin
            if (fifo_empty) state_d = LAST;
            else            load_c  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LAST: begin
        // cnt is cleared at the LAST rise so the fall right after it can be told apart.
        if (rise_c) begin
          txd_d = 1'b0;
          cnt_d = '0;
        end else if (fall_c && cnt_q == '0) begin
          oe_b_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      shreg_d = fifo_rdata;
      rd_d    = 1'b1;
      fss_d   = 1'b1;
      state_d = FRAME;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      SSPTXD    <= 1'b0;
      SSPFSSOUT <= 1'b0;
      SSPOE_B   <= 1'b1;
      fifo_rd   <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      SSPTXD    <= txd_d;
      SSPFSSOUT <= fss_d;
      SSPOE_B   <= oe_b_d;
      fifo_rd   <= rd_d;
      tx_busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Self-checking bench for ssp_tx_ctrl: FIFO model plus a pin-level reference
// computed from frame timing arithmetic (frame start edge, bit slots, OE window).
module tb_ssp_tx_ctrl;

  localparam int unsigned W = 8;
  localparam int          P = 2 * int'(W);   // PCLK edges per byte slot

  logic         PCLK = 1'b0;
  logic         CLEAR_B;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         fifo_rd, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, tx_busy;

  logic [W-1:0] fmem [64];
  int           wp = 0;
  int           rp = 0;
  int           ecnt = 0;
  int           total = 0;
  int           bad = 0;

  // Reference model inputs: first FSS rise edge, number of bytes, byte values.
  int           r0 = 0;
  int           mn = 0;
  logic [W-1:0] mb [4];

  logic [5:0]   pins;
  assign pins       = {SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, fifo_rd, tx_busy};
  assign fifo_empty = (wp == rp);
  assign fifo_rdata = fmem[rp[5:0]];

  ssp_tx_ctrl dut (
    .PCLK       (PCLK),
    .CLEAR_B    (CLEAR_B),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .SSPCLKOUT  (SSPCLKOUT),
    .SSPFSSOUT  (SSPFSSOUT),
    .SSPTXD     (SSPTXD),
    .SSPOE_B    (SSPOE_B),
    .tx_busy    (tx_busy)
  );

  always #5 PCLK = ~PCLK;

  // Edge number since reset release; odd edges are SSPCLKOUT rises.
  always @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  always @(posedge PCLK) begin
    if (fifo_rd && wp != rp) rp <= rp + 1;
  end

  // Expected {SSPCLKOUT, FSS, TXD, OE_B, fifo_rd, tx_busy} after edge c.
  function automatic logic [5:0] model(input int c);
    int           d, k, j;
    logic         fss, txd, oe_b, rd, busy;
    logic [W-1:0] tmp;
    d    = c - r0;
    fss  = 1'b0;
    txd  = 1'b0;
    oe_b = 1'b1;
    rd   = 1'b0;
    busy = 1'b0;
    if (mn > 0 && d >= 0) begin
      fss  = (d < P * mn) && (d % P < 2);
      rd   = (d < P * mn) && (d % P == 0);
      busy = (d < P * mn + 3);
      oe_b = !(d >= 1 && d < P * mn + 3);
      if (d >= 2 && d < 2 + P * mn) begin
        k   = (d - 2) / P;
        j   = ((d - 2) % P) / 2;
        tmp = mb[k];
        txd = tmp[W-1-j];
      end
    end
    return {1'(c % 2), fss, txd, oe_b, rd, busy};
  endfunction

  task automatic push(input logic [W-1:0] b);
    fmem[wp[5:0]] = b;
    wp = wp + 1;
  endtask

  // Queue mb[0..n-1]; the first frame starts on the next rise edge.
  task automatic start(input int n);
    mn = n;
    r0 = (ecnt % 2 == 0) ? ecnt + 1 : ecnt + 2;
    for (int k = 0; k < n; k++) push(mb[k]);
  endtask

  task automatic test_reset();
    logic [5:0] want;
    int         p0;
    mn = 0;
    CLEAR_B = 1'b0;
    repeat (3) @(negedge PCLK);
    total++;
    if (pins !== 6'b000100) begin
      bad++;
      $display("FAIL reset_por got=%b want=000100", pins);
    end
    CLEAR_B = 1'b1;
    mb[0] = W'($urandom);
    p0 = rp;
    start(1);
    for (int i = 0; i < 9; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL reset_pre edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
    CLEAR_B = 1'b0;
    #1;
    total++;
    if (pins !== 6'b000100) begin
      bad++;
      $display("FAIL reset_async got=%b want=000100", pins);
    end
    mn = 0;
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL reset_post edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
    total++;
    if (rp - p0 != 1) begin
      bad++;
      $display("FAIL reset_pops got=%0d want=1", rp - p0);
    end
  endtask

  task automatic test_single();
    logic [5:0] want;
    int         rds, oe_low;
    rds = 0;
    oe_low = 0;
    mb[0] = 8'hA5;
    start(1);
    for (int i = 0; i < P + 8; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      rds += int'(fifo_rd);
      oe_low += int'(!SSPOE_B);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL single edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
    total++;
    if (rds != 1) begin
      bad++;
      $display("FAIL single_rd got=%0d want=1", rds);
    end
    total++;
    if (oe_low != 2 * (int'(W) + 1)) begin
      bad++;
      $display("FAIL single_oe got=%0d want=%0d", oe_low, 2 * (int'(W) + 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] want;
    int         rds, oe_low;
    rds = 0;
    oe_low = 0;
    mb[0] = 8'h81;
    mb[1] = 8'h7E;
    start(2);
    for (int i = 0; i < 2 * P + 8; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      rds += int'(fifo_rd);
      oe_low += int'(!SSPOE_B);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL b2b edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
    total++;
    if (rds != 2) begin
      bad++;
      $display("FAIL b2b_rd got=%0d want=2", rds);
    end
    total++;
    if (oe_low != 34) begin
      bad++;
      $display("FAIL b2b_oe got=%0d want=34", oe_low);
    end
  endtask

  task automatic test_idle();
    logic [5:0] want;
    mn = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL idle edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [5:0] want;
    int         p0, nloop;
    mb[0] = 8'hFF;
    mb[1] = W'($urandom);
    p0 = rp;
    start(2);
    nloop = r0 + 7 - ecnt;
    for (int i = 0; i < nloop; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL mid_pre edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
    CLEAR_B = 1'b0;
    #1;
    total++;
    if (pins !== 6'b000100) begin
      bad++;
      $display("FAIL mid_async got=%b want=000100", pins);
    end
    mn = 0;
    @(negedge PCLK);
    mb[0] = mb[1];
    mn = 1;
    r0 = ecnt + 1;
    CLEAR_B = 1'b1;
    for (int i = 0; i < P + 8; i++) begin
      @(negedge PCLK);
      want = model(ecnt);
      total++;
      if (pins !== want) begin
        bad++;
        $display("FAIL mid_post edge=%0d got=%b want=%b", ecnt, pins, want);
      end
    end
    total++;
    if (rp - p0 != 2 || wp != rp) begin
      bad++;
      $display("FAIL mid_pops got=%0d left=%0d want=2 left=0", rp - p0, wp - rp);
    end
  endtask

  task automatic test_align();
    logic [5:0] want;
    int         c0, first;
    for (int m = 0; m < 2; m++) begin
      @(negedge PCLK);
      if ((ecnt % 2) != m) @(negedge PCLK);
      mb[0] = W'($urandom);
      c0 = ecnt;
      first = -1;
      start(1);
      for (int i = 0; i < P + 8; i++) begin
        @(negedge PCLK);
        want = model(ecnt);
        if (first < 0 && SSPFSSOUT === 1'b1) first = ecnt - c0;
        total++;
        if (pins !== want) begin
          bad++;
          $display("FAIL align%0d edge=%0d got=%b want=%b", m, ecnt, pins, want);
        end
      end
      total++;
      if (first != m + 1) begin
        bad++;
        $display("FAIL align%0d_delay got=%0d want=%0d", m, first, m + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] want;
    int         n, p0;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge PCLK);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) mb[k] = W'($urandom);
      p0 = rp;
      start(n);
      for (int i = 0; i < P * n + 8; i++) begin
        @(negedge PCLK);
        want = model(ecnt);
        total++;
        if (pins !== want) begin
          bad++;
          $display("FAIL rand%0d edge=%0d got=%b want=%b", it, ecnt, pins, want);
        end
      end
      total++;
      if (rp - p0 != n) begin
        bad++;
        $display("FAIL rand%0d_pops got=%0d want=%0d", it, rp - p0, n);
      end
    end
  endtask

  initial begin
    CLEAR_B = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_idle();
    test_reset_midframe();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
